// File: rtl/ring_mem_station_if.sv
// Core request/response and ring hop channels of one ring_mem_station.
// The slave modport is the station's view; master is the surrounding core and ring.
interface ring_mem_station_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic        req_wen;
  logic [31:0] req_data;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  logic        io_prev_ready;
  logic        io_prev_valid;
  logic [31:0] io_prev_bits_address;
  logic [31:0] io_prev_bits_data;
  logic        io_prev_bits_wen;
  logic [7:0]  io_prev_bits_id;

  logic        io_next_ready;
  logic        io_next_valid;
  logic [31:0] io_next_bits_address;
  logic [31:0] io_next_bits_data;
  logic        io_next_bits_wen;
  logic [7:0]  io_next_bits_id;

  logic        err_unexpected;

  modport slave (
    input  req_valid, req_address, req_wen, req_data, resp_ready,
           io_prev_valid, io_prev_bits_address, io_prev_bits_data,
           io_prev_bits_wen, io_prev_bits_id, io_next_ready,
    output req_ready, resp_valid, resp_data, io_prev_ready,
           io_next_valid, io_next_bits_address, io_next_bits_data,
           io_next_bits_wen, io_next_bits_id, err_unexpected
  );

  modport master (
    output req_valid, req_address, req_wen, req_data, resp_ready,
           io_prev_valid, io_prev_bits_address, io_prev_bits_data,
           io_prev_bits_wen, io_prev_bits_id, io_next_ready,
    input  req_ready, resp_valid, resp_data, io_prev_ready,
           io_next_valid, io_next_bits_address, io_next_bits_data,
           io_next_bits_wen, io_next_bits_id, err_unexpected
  );
endinterface

// File: rtl/ring_mem_station.sv
// Ring memory station: injects one core load/store at a time onto the ring,
// forwards foreign packets, and captures the read response tagged with ID.
module ring_mem_station #(
  parameter logic [7:0] ID         = 8'd0,
  parameter int         STARVE_MAX = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  ring_mem_station_if.slave     bus
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  starve;
  logic [31:0] rq_addr, rq_data;
  logic        rq_wen;
  logic        nv, nw;
  logic [31:0] na, nd;
  logic [7:0]  nid;
  logic [31:0] rs_data;
  logic        err;

  logic own_pkt, can_load, force_inj, prev_ready;
  logic own_fire, fwd_fire, inject, req_fire;

  assign own_pkt    = (bus.io_prev_bits_id == ID);
  assign can_load   = !nv || bus.io_next_ready;
  assign force_inj  = (state == S_SEND) && (starve == STARVE_LIM);
  // Own responses only need the response buffer; they never wait on the output register.
  assign prev_ready = own_pkt ? (state != S_RESP) : (can_load && !force_inj);
  assign own_fire   = bus.io_prev_valid && own_pkt && prev_ready;
  assign fwd_fire   = bus.io_prev_valid && !own_pkt && prev_ready;
  assign inject     = (state == S_SEND) && can_load && !fwd_fire;
  assign req_fire   = (state == S_IDLE) && bus.req_valid;

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = S_SEND;
      end
      S_SEND: if (inject) state_nxt = rq_wen ? S_IDLE : S_WAIT;
      S_WAIT: if (own_fire) state_nxt = S_RESP;
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      starve  <= '0;
      rq_addr <= '0;
      rq_data <= '0;
      rq_wen  <= 1'b0;
      nv      <= 1'b0;
      na      <= '0;
      nd      <= '0;
      nw      <= 1'b0;
      nid     <= '0;
      rs_data <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_fire) begin
        rq_addr <= bus.req_address;
        rq_data <= bus.req_data;
        rq_wen  <= bus.req_wen;
      end
      // fwd_fire in S_SEND implies starve < STARVE_LIM, so the count saturates there.
      if (state != S_SEND || inject) starve <= '0;
      else if (fwd_fire)             starve <= starve + 4'd1;
      if (fwd_fire) begin
        nv  <= 1'b1;
        na  <= bus.io_prev_bits_address;
        nd  <= bus.io_prev_bits_data;
        nw  <= bus.io_prev_bits_wen;
        nid <= bus.io_prev_bits_id;
      end else if (inject) begin
        nv  <= 1'b1;
        na  <= rq_addr;
        nd  <= rq_data;
        nw  <= rq_wen;
        nid <= ID;
      end else if (bus.io_next_ready) begin
        nv  <= 1'b0;
      end
      if (own_fire && state == S_WAIT) rs_data <= bus.io_prev_bits_data;
      if (own_fire && state != S_WAIT) err <= 1'b1;
    end
  end

  assign bus.io_prev_ready        = prev_ready;
  assign bus.io_next_valid        = nv;
  assign bus.io_next_bits_address = na;
  assign bus.io_next_bits_data    = nd;
  assign bus.io_next_bits_wen     = nw;
  assign bus.io_next_bits_id      = nid;
  assign bus.resp_data            = rs_data;
  assign bus.err_unexpected       = err;
endmodule

// File: doc/ring_mem_station.md
# ring_mem_station

Core-side memory access point on the multicore ring. It takes single load/store requests from a core, injects them onto the ring's `io_next` channel tagged with this station's ID, and accepts the matching read response from `io_prev`. Every packet that carries another station's ID is forwarded unchanged. It is the initiator counterpart of the ring-terminating memory responder, and one instance sits between each pair of adjacent ring hops.

## Interface
- `ID`, 8'd0: this station's tag; responses with `bits_id == ID` are consumed.
- `STARVE_MAX`, 4: consecutive forward wins tolerated before one injection is forced; range 1..15.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_address` in 32: byte address.
- `req_wen` in 1: 1 = store (posted), 0 = load.
- `req_data` in 32: store data; ignored for loads.
- `resp_valid` out 1: load data available.
- `resp_ready` in 1: core takes the response.
- `resp_data` out 32: load data.
- `io_prev_ready` out 1: ring-input ready.
- `io_prev_valid` in 1: ring-input valid.
- `io_prev_bits_address` in 32: ring-input address.
- `io_prev_bits_data` in 32: ring-input data.
- `io_prev_bits_wen` in 1: ring-input write enable.
- `io_prev_bits_id` in 8: ring-input tag.
- `io_next_ready` in 1: ring-output ready.
- `io_next_valid` out 1: ring-output valid.
- `io_next_bits_address` out 32: ring-output address.
- `io_next_bits_data` out 32: ring-output data.
- `io_next_bits_wen` out 1: ring-output write enable.
- `io_next_bits_id` out 8: ring-output tag.
- `err_unexpected` out 1: sticky; set when a response arrives for this ID that was not expected.

## Operation
- Output register: a one-entry buffer drives all `io_next_*` signals.
  - It may load when it is empty, or when it is draining in the same cycle (`io_next_valid & io_next_ready`).
  - While `io_next_valid=1` and `io_next_ready=0`, the bits stay stable.
- Packet classes on `io_prev`:
  - Own: `io_prev_bits_id == ID`. Routed to the response buffer.
  - Foreign: any other ID. Routed to the output register.
- `io_prev_ready` is set as follows:
  - Own packet: 1 when the response buffer is empty.
  - Foreign packet: 1 when the output register can load and no injection is forced this cycle.
- Station FSM:
  - sIdle: `req_ready=1`. On accept, latch the request and go to sSend.
  - sSend: inject into the output register with `{address, data, wen, id=ID}` when it can load and no foreign packet wins arbitration.
    - Store: go to sIdle.
    - Load: go to sWait.
  - sWait: an own packet fire latches `bits_data` into the response buffer, then go to sResp.
  - sResp: hold `resp_valid=1` and `resp_data`. When `resp_ready=1`, go to sIdle.
- Arbitration for the output register, evaluated in sSend only:
  - A foreign packet wins by default, and the starve counter increments.
  - When the counter equals `STARVE_MAX`, the injection wins. `io_prev_ready` is held 0 for foreign packets that cycle.
  - The counter clears on every injection and in every non-sSend state. It never exceeds `STARVE_MAX`.
- An own packet fire in any state other than sWait is accepted and dropped, and sets `err_unexpected`.
- At most one request is outstanding; there is no ID reuse or reordering.

## Timing
- Reset values (`reset_n=0`, asynchronous):
  - state = sIdle, `req_ready=1`.
  - `io_next_valid=0`, `resp_valid=0`, `err_unexpected=0`, starve counter = 0.
  - `io_prev_ready` follows its combinational rule (empty buffers).
  - `io_next_bits_*` and `resp_data` are 0.
- Injection latency: request accept in cycle N puts `io_next_valid=1` in cycle N+2 (the sSend register load happens in cycle N+1), assuming no contention.
- Forwarding latency: a foreign fire in cycle N puts the packet on `io_next` in cycle N+1. Throughput is 1 packet/cycle while `io_next_ready=1`.
- Response latency: an own fire in cycle N gives `resp_valid=1` in cycle N+1. `req_ready` returns to 1 in the cycle after `resp_valid & resp_ready`.
- Simultaneous own fire and foreign backpressure: the two classes are independent. A stalled output register does not block the consumption of own responses.
- Reset mid-operation:
  - All in-flight state is discarded, including any packet in the output register.
  - A later response for the lost load raises `err_unexpected`.

## Test plan
- Load, ring idle (`ID=3`):
  - Stimulus: request addr 0x40 accepted at cycle 0; responder returns id 3, data 0xDEADBEEF at cycle 6.
  - Required: `io_next` shows {0x40, wen 0, id 3} at cycle 2; `resp_valid=1` with `resp_data=0xDEADBEEF` at cycle 7; `req_ready=1` after the handshake.
- Posted store:
  - Stimulus: request addr 0x10, data 0x55.
  - Required: `io_next` shows {0x10, 0x55, wen 1, id 3}; the FSM returns to sIdle the cycle after injection; no response is awaited.
- Foreign forwarding:
  - Stimulus: 8 back-to-back packets with id 5, `io_next_ready=1`.
  - Required: each appears on `io_next` one cycle later, bit-identical; `io_prev_ready` stays 1.
- Starvation (`STARVE_MAX=4`):
  - Stimulus: pending load plus continuous foreign traffic.
  - Required: 4 foreign packets pass, then the injection goes out while `io_prev_ready=0` for one cycle, then forwarding resumes.
- Backpressure:
  - Stimulus: `io_next_ready=0` for 5 cycles with a packet held.
  - Required: bits stay stable and `io_prev_ready=0` for foreign packets.
- Unexpected response and reset:
  - Stimulus: an id 3 packet arrives in sIdle; later, `reset_n` is pulsed while in sWait.
  - Required: the packet is consumed and `err_unexpected=1`; reset clears the flag, `io_next_valid`, `resp_valid` and the FSM state immediately.
